// File: rtl/mmio_pkg.sv
// Shared IO word map and status-word layout for the memory-stage IO responders.
package mmio_pkg;

  localparam int unsigned WORD_W    = 5;
  localparam int unsigned CHGCNT_W  = 8;

  localparam logic [WORD_W-1:0] WORD_IN1    = 5'b11111;
  localparam logic [WORD_W-1:0] WORD_IN2    = 5'b11110;
  localparam logic [WORD_W-1:0] WORD_OUT    = 5'b11101;
  localparam logic [WORD_W-1:0] WORD_STATUS = 5'b11100;
  localparam logic [WORD_W-1:0] WORD_CTRL   = 5'b11011;

  localparam int unsigned ST_CHG1    = 0;
  localparam int unsigned ST_CHG2    = 1;
  localparam int unsigned ST_OVR1    = 2;
  localparam int unsigned ST_OVR2    = 3;
  localparam int unsigned ST_CNT_LSB = 8;

  typedef struct packed {
    logic [CHGCNT_W-1:0] chg_count;
    logic                ovr2;
    logic                ovr1;
    logic                chg2;
    logic                chg1;
  } status_t;

  // Place the status fields at their architectural bit positions.
  function automatic logic [31:0] status_word(input status_t s);
    logic [31:0] w;
    w = '0;
    w[ST_CHG1] = s.chg1;
    w[ST_CHG2] = s.chg2;
    w[ST_OVR1] = s.ovr1;
    w[ST_OVR2] = s.ovr2;
    w[ST_CNT_LSB +: CHGCNT_W] = s.chg_count;
    return w;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus candidate/counter debounce for one 4-bit input port.
module input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] i_pin,
  output logic [3:0] o_stable,
  output logic       o_update_c
);

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_cand;
  logic [3:0]       r_stable;
  logic [CNT_W-1:0] r_cnt;

  logic [3:0]       w_cand_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_update;

  // Update fires on the cycle whose count would reach DEBOUNCE_CYCLES.
  always_comb begin
    w_cand_nxt = r_cand;
    w_cnt_nxt  = r_cnt;
    w_update   = 1'b0;
    if (r_sync2 == r_stable) begin
      w_cnt_nxt = '0;
    end else begin
      if (r_sync2 != r_cand) begin
        w_cand_nxt = r_sync2;
        w_cnt_nxt  = CNT_W'(1);
      end else begin
        w_cnt_nxt  = r_cnt + CNT_W'(1);
      end
      if (w_cnt_nxt == CNT_W'(DEBOUNCE_CYCLES)) begin
        w_update  = 1'b1;
        w_cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cand   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1  <= i_pin;
      r_sync2  <= r_sync1;
      r_cand   <= w_cand_nxt;
      r_cnt    <= w_cnt_nxt;
      if (w_update) r_stable <= w_cand_nxt;
    end
  end

  assign o_stable   = r_stable;
  assign o_update_c = w_update;

endmodule

// File: rtl/mmio_input_responder.sv
// Memory-mapped responder for the two debounced input ports: data, status flags, control and irq.
module mmio_input_responder
  import mmio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        mrd,
  input  logic        mwmem,
  input  logic [31:0] datain,
  input  logic [3:0]  input_port1,
  input  logic [3:0]  input_port2,
  output logic [31:0] io_rdata,
  output logic        irq
);

  logic [3:0]        w_stable1;
  logic [3:0]        w_stable2;
  logic              w_upd1;
  logic              w_upd2;
  logic [WORD_W-1:0] w_word;
  logic              w_wr;
  logic              w_rd;
  logic              w_clr1;
  logic              w_clr2;
  logic [3:0]        w_w1c;
  logic [31:0]       w_rdata;
  status_t           w_st_nxt;
  status_t           r_st;
  logic              r_irq_en;
  logic              w_unused_bits;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb1 (
    .clock      (clock),
    .reset      (reset),
    .i_pin      (input_port1),
    .o_stable   (w_stable1),
    .o_update_c (w_upd1)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb2 (
    .clock      (clock),
    .reset      (reset),
    .i_pin      (input_port2),
    .o_stable   (w_stable2),
    .o_update_c (w_upd2)
  );

  // A store wins over a simultaneous load; nothing outside the IO window is decoded.
  assign w_word = address[6:2];
  assign w_wr   = mwmem & address[7];
  assign w_rd   = mrd & ~mwmem & address[7];
  assign w_clr1 = w_rd && (w_word == WORD_IN1);
  assign w_clr2 = w_rd && (w_word == WORD_IN2);
  assign w_w1c  = (w_wr && (w_word == WORD_STATUS)) ? datain[3:0] : 4'h0;

  assign w_unused_bits = ^{address[31:8], address[1:0], datain[31:4]};

  always_comb begin
    w_rdata = '0;
    case (w_word)
      WORD_IN1:    w_rdata = {28'h0, w_stable1};
      WORD_IN2:    w_rdata = {28'h0, w_stable2};
      WORD_STATUS: w_rdata = status_word(r_st);
      WORD_CTRL:   w_rdata = {31'h0, r_irq_en};
      WORD_OUT:    w_rdata = '0;
      default:     w_rdata = '0;
    endcase
  end

  // Clears are applied first so a same-cycle update (set) wins; a data read still drops overrun.
  always_comb begin
    w_st_nxt = r_st;
    if (w_clr1) begin
      w_st_nxt.chg1 = 1'b0;
      w_st_nxt.ovr1 = 1'b0;
    end
    if (w_clr2) begin
      w_st_nxt.chg2 = 1'b0;
      w_st_nxt.ovr2 = 1'b0;
    end
    if (w_w1c[ST_CHG1]) w_st_nxt.chg1 = 1'b0;
    if (w_w1c[ST_CHG2]) w_st_nxt.chg2 = 1'b0;
    if (w_w1c[ST_OVR1]) w_st_nxt.ovr1 = 1'b0;
    if (w_w1c[ST_OVR2]) w_st_nxt.ovr2 = 1'b0;
    if (w_upd1) begin
      w_st_nxt.chg1 = 1'b1;
      if (r_st.chg1 && !w_clr1) w_st_nxt.ovr1 = 1'b1;
    end
    if (w_upd2) begin
      w_st_nxt.chg2 = 1'b1;
      if (r_st.chg2 && !w_clr2) w_st_nxt.ovr2 = 1'b1;
    end
    w_st_nxt.chg_count = r_st.chg_count + CHGCNT_W'(w_upd1) + CHGCNT_W'(w_upd2);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_st     <= '0;
      r_irq_en <= 1'b0;
      io_rdata <= '0;
      irq      <= 1'b0;
    end else begin
      r_st <= w_st_nxt;
      if (w_rd) io_rdata <= w_rdata;
      if (w_wr && (w_word == WORD_CTRL)) r_irq_en <= datain[0];
      irq <= r_irq_en & (r_st.chg1 | r_st.chg2);
    end
  end

endmodule
